// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage that sits directly upstream of sequence_detector.
// It accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// one bit per clock on x. A one-word holding register lets the next word
// stream out with no idle cycle, so a pattern can span a word boundary.
//
// Handshake: a word is transferred at a rising edge where in_valid and
// in_ready are both high. in_ready is decoded from registers only and never
// looks at in_valid. in_data is sampled only at the accepting edge.
//
// Parameters:
//   WIDTH     - word width in bits (>= 2)
//   MSB_FIRST - 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_BIT  - level driven on x when no word is being shifted
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_data    in   parallel word to serialize
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a word this cycle (hold register empty)
//   x          out  serial bit stream
//   x_valid    out  x carries a data bit this cycle
//   word_done  out  high during the cycle x carries the last bit of a word
//   busy       out  shifter active or hold register occupied
//   dbg_state  out  current FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy,
  output logic             dbg_state
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_accept  = in_valid && !r_hold_full;
  assign w_last    = (r_cnt == LAST);
  assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

  // Shift toward whichever end currently drives x.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_shreg     <= r_hold;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_last) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + CW'(1);
          end else if (r_hold_full) begin
            // Gapless reload: the next word's first bit follows the
            // current word's last bit directly.
            r_shreg     <= r_hold;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Accept only happens with the hold register empty, and draining only
      // happens with it full, so this never collides with the clears above.
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign in_ready  = !r_hold_full;
  assign x_valid   = (r_state == S_SHIFT);
  assign x         = x_valid ? w_out_bit : IDLE_BIT;
  assign word_done = x_valid && w_last;
  assign busy      = (r_state == S_SHIFT) || r_hold_full;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Two instances share one clock and reset:
//   dut_a : WIDTH=8, MSB_FIRST=1, IDLE_BIT=0
//   dut_b : WIDTH=8, MSB_FIRST=0, IDLE_BIT=1
// Each accepted word pushes its expected {bit, word_done} sequence into a
// queue; a monitor per instance pops and compares on every x_valid cycle and
// checks the idle level otherwise. The dut_a monitor also records the length
// of each x_valid run and each idle gap between runs, for the gap tests.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic [7:0] a_in_data;
  logic       a_in_valid, a_in_ready, a_x, a_x_valid, a_word_done, a_busy, a_dbg;
  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_x, b_x_valid, b_word_done, b_busy, b_dbg;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .x(a_x), .x_valid(a_x_valid),
    .word_done(a_word_done), .busy(a_busy), .dbg_state(a_dbg)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .x(b_x), .x_valid(b_x_valid),
    .word_done(b_word_done), .busy(b_busy), .dbg_state(b_dbg)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_b_q[$];
  int         run_q[$];
  int         gap_q[$];
  int         run_len = 0;
  int         gap_len = 0;
  bit         had_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial order of one word: {bit, word_done} per cycle.
  task automatic push_exp(input bit sel, input logic [7:0] d, input bit msb);
    logic [1:0] item;
    for (int i = 0; i < 8; i++) begin
      item[1] = msb ? d[7-i] : d[i];
      item[0] = (i == 7);
      if (sel) exp_b_q.push_back(item);
      else     exp_q.push_back(item);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input bit keep_valid);
    int t = 0;
    @(negedge clk);
    a_in_data  = d;
    a_in_valid = 1'b1;
    while (!a_in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("a_accept_timeout", a_in_ready, 1);
    @(posedge clk);
    #1;
    push_exp(1'b0, d, 1'b1);
    if (!keep_valid) a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    b_in_data  = d;
    b_in_valid = 1'b1;
    while (!b_in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("b_accept_timeout", b_in_ready, 1);
    @(posedge clk);
    #1;
    push_exp(1'b1, d, 1'b0);
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("drain_timeout", exp_q.size() + exp_b_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_run(input string name, input int base, input int off, input int exp);
    if (run_q.size() > base + off) chk(name, run_q[base+off], exp);
    else chk(name, run_q.size(), base + off + 1);
  endtask

  task automatic chk_gap(input string name, input int base, input int off, input int exp);
    if (gap_q.size() > base + off) chk(name, gap_q[base+off], exp);
    else chk(name, gap_q.size(), base + off + 1);
  endtask

  // Monitor for dut_a: scoreboard plus run/gap recording.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
      end else if (a_x_valid) begin
        if (exp_q.size() == 0) begin
          chk("a_unexpected_bit", a_x_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("a_x", a_x, e[1]);
          chk("a_word_done", a_word_done, e[0]);
        end
      end else begin
        chk("a_idle_x", a_x, 0);
        chk("a_idle_done", a_word_done, 0);
      end
      if (a_x_valid) begin
        if (run_len == 0 && had_run) gap_q.push_back(gap_len);
        run_len++;
        gap_len = 0;
      end else begin
        if (run_len > 0) begin
          run_q.push_back(run_len);
          had_run = 1'b1;
        end
        run_len = 0;
        gap_len++;
      end
    end
  end

  // Monitor for dut_b.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_b_q.delete();
      end else if (b_x_valid) begin
        if (exp_b_q.size() == 0) begin
          chk("b_unexpected_bit", b_x_valid, 0);
        end else begin
          e = exp_b_q.pop_front();
          chk("b_x", b_x, e[1]);
          chk("b_word_done", b_word_done, e[0]);
        end
      end else begin
        chk("b_idle_x", b_x, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r;
    int base_g;
    reset      = 1'b0;
    a_in_data  = '0;
    a_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_x", a_x, 0);
    chk("rst_x_valid", a_x_valid, 0);
    chk("rst_word_done", a_word_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_state", a_dbg, 0);
    chk("rst_b_x", b_x, 1);
    reset = 1'b1;

    // Single word 8'hA5, MSB first
    base_r = run_q.size();
    send_a(8'hA5, 1'b0);
    chk("t1_busy_held", a_busy, 1);
    chk("t1_ready_low", a_in_ready, 0);
    drain();
    chk_run("t1_run", base_r, 0, 8);
    chk("t1_after_busy", a_busy, 0);
    chk("t1_after_valid", a_x_valid, 0);
    chk("t1_after_ready", a_in_ready, 1);

    // Back-to-back 8'hB4 then 8'hFF with in_valid held high
    base_r = run_q.size();
    send_a(8'hB4, 1'b1);
    send_a(8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t2_ready_low", a_in_ready, 0);
      chk("t2_busy", a_busy, 1);
    end
    @(negedge clk);
    chk("t2_ready_after_reload", a_in_ready, 1);
    drain();
    chk_run("t2_run", base_r, 0, 16);

    // Second word presented exactly at the last-bit edge of 8'h80
    base_r = run_q.size();
    base_g = gap_q.size();
    send_a(8'h80, 1'b0);
    repeat (9) @(negedge clk);
    chk("t3_last_bit_done", a_word_done, 1);
    chk("t3_ready_at_last", a_in_ready, 1);
    a_in_data  = 8'h01;
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    push_exp(1'b0, 8'h01, 1'b1);
    a_in_valid = 1'b0;
    drain();
    chk_run("t3_run0", base_r, 0, 8);
    chk_run("t3_run1", base_r, 1, 8);
    chk_gap("t3_gap", base_g, 1, 1);

    // Reset mid-word after three bits of 8'hFF
    send_a(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t4_x", a_x, 0);
    chk("t4_x_valid", a_x_valid, 0);
    chk("t4_in_ready", a_in_ready, 1);
    chk("t4_busy", a_busy, 0);
    chk("t4_word_done", a_word_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_no_residual", a_x_valid, 0);
      chk("t4_idle_busy", a_busy, 0);
    end
    chk("t4_flushed", exp_q.size(), 0);

    // Detector-facing pattern 8'b1010_0000, then a quiet line
    send_a(8'hA0, 1'b0);
    drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_quiet_x", a_x, 0);
      chk("t5_quiet_valid", a_x_valid, 0);
    end

    // LSB-first instance with IDLE_BIT=1
    send_b(8'h01);
    drain();
    send_b(8'hC3);
    drain();
    chk("t6_b_idle_x", b_x, 1);
    chk("t6_b_busy", b_busy, 0);
    chk("t6_b_ready", b_in_ready, 1);

    chk("final_queues", exp_q.size() + exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of sequence_detector. Accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the serial line x, which connects to the detector's x input. A one-word holding register lets back-to-back words stream with no idle gap, so multi-word patterns can span word boundaries.

Parameters:
WIDTH, 8, word width in bits (>= 2)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 0, value driven on x when no word is being shifted

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
x  output  1  serial bit stream (feeds sequence_detector x)
x_valid  output  1  x carries a data bit this cycle
word_done  output  1  high during the cycle x carries the last bit of a word
busy  output  1  shifter active or holding register occupied

Behaviour:
- Storage: hold register (WIDTH) plus hold_full flag; shift register shreg (WIDTH); bit counter cnt (clog2(WIDTH) bits); state IDLE or SHIFT.
- Reset (reset==0, asynchronous): state=IDLE, hold_full=0, cnt=0, shreg=0. Outputs: in_ready=1, x=IDLE_BIT, x_valid=0, word_done=0, busy=0. Any in-flight or held word is discarded.
- in_ready = !hold_full, decoded from registers only, never from in_valid.
- Accept: a word is taken at a rising edge where in_valid && in_ready, and is written to hold. hold_full is set.
- IDLE: x=IDLE_BIT, x_valid=0. At an edge with hold_full=1, set shreg=hold, hold_full=0, cnt=0, and enter SHIFT.
- SHIFT: x = shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0]. x_valid=1.
  - Each edge with cnt<WIDTH-1: shift shreg toward the output end, then cnt++.
  - Edge with cnt==WIDTH-1: if hold_full, reload shreg from hold, set cnt=0, clear hold_full, and stay in SHIFT. This gives a gapless next word. Otherwise return to IDLE.
- Latency: word accepted at edge N is loaded at edge N+1. Its first bit is on x from edge N+1 until edge N+2. Its last bit is on x during cycle N+WIDTH.
- Back-to-back: a word accepted before the last-bit edge follows with zero gap. A word accepted exactly at the last-bit edge of the current word (hold was empty) gives exactly one IDLE cycle between words.
- Simultaneous accept and hold drain cannot occur, because in_ready=0 whenever hold_full=1.
- word_done = x_valid && (cnt==WIDTH-1).
- busy = (state==SHIFT) || hold_full.
- in_data may change freely while in_ready=0. Only the value present at the accepting edge is used.
- Reset asserted mid-word: x returns to IDLE_BIT immediately (asynchronously). After release, no residual bits are emitted.

Test Plan:
- WIDTH=8, MSB_FIRST=1: accept 8'hA5 -> x = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with x_valid=1; word_done only on the 8th cycle; afterwards x=0, x_valid=0, busy=0.
- Back-to-back: accept 8'hB4, then 8'hFF on the next cycle with in_valid held high -> 16 contiguous x_valid cycles: 1,0,1,1,0,1,0,0 then eight 1s. in_ready=0 from the second accept until the reload edge. word_done pulses on cycles 8 and 16.
- Late second word: present 8'h01 only at the last-bit edge of 8'h80 -> exactly one cycle with x_valid=0 between the two words.
- MSB_FIRST=0: accept 8'h01 -> x = 1,0,0,0,0,0,0,0.
- Reset mid-word: drop reset after 3 bits of 8'hFF -> x=0, x_valid=0, in_ready=1 immediately. After release with no input, x_valid stays 0.
- Integration with sequence_detector: serialize 8'b1010_0000 -> detector sees x = 1,0,1,0,0,0,0,0 and z asserts once after the 1,0,1 prefix. With in_valid held low, x stays IDLE_BIT=0 and z stays 0.
